cpu_clk_ctrl: RTL

Run/step controller for the multi-cycle CPU clock. It replaces the free-running divided clock with a single-cycle clock-enable pulse (`cpu_ce`) that the CPU datapath qualifies every register update with. Three sources drive it: a run switch (continuous stepping at a programmable divided rate), a debounced single-step pushbutton, and a halt request from the CPU. It also keeps a count of executed CPU cycles for the display logic.

---
 rtl/cpu_clk_ctrl_if.sv | 23 ++
 rtl/cpu_clk_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between the board-level controls and the CPU clock-enable controller.
interface cpu_clk_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             step_btn;
    logic             halt;
    logic [CNT_W-1:0] div_max;
    logic             cpu_ce;
    logic [CNT_W-1:0] cycle_cnt;
    logic [1:0]       state;
    logic             halted;

    modport master (
        output run, step_btn, halt, div_max,
        input  cpu_ce, cycle_cnt, state, halted
    );

    modport slave (
        input  run, step_btn, halt, div_max,
        output cpu_ce, cycle_cnt, state, halted
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller producing a one-cycle CPU clock-enable pulse,
// with a debounced single-step button and an executed-cycle counter.
module cpu_clk_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 32
) (
    input logic            clk,
    input logic            rst_n,
    cpu_clk_ctrl_if.slave  bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    logic             run_meta, run_s;
    logic             btn_meta, btn_s;
    logic [DB_W-1:0]  db_cnt;
    logic             db_level;
    logic             step_evt;
    state_t           state_q;
    logic [CNT_W-1:0] div_cnt;
    logic             cpu_ce_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic             halted_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the 2-flop synchronizer into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_meta <= 1'b0;
            run_s    <= 1'b0;
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            run_meta <= bus.run;
            run_s    <= run_meta;
            btn_meta <= bus.step_btn;
            btn_s    <= btn_meta;
        end
    end

    // The level is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle;
    // step_evt is raised in the same edge that the level rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
            step_evt <= 1'b0;
        end else begin
            step_evt <= 1'b0;
            if (btn_s == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= btn_s;
                db_cnt   <= '0;
                step_evt <= btn_s;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_cnt     <= '0;
            cpu_ce_q    <= 1'b0;
            cycle_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            cpu_ce_q <= 1'b0;
            if (cpu_ce_q) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);

            case (state_q)
                IDLE: begin
                    if (bus.halt) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (run_s) begin
                        state_q <= RUN;
                        div_cnt <= '0;
                    end else if (step_evt) begin
                        state_q <= STEP;
                    end
                end
                RUN: begin
                    if (bus.halt) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (!run_s) begin
                        state_q <= IDLE;
                        div_cnt <= '0;
                    end else if (div_cnt >= bus.div_max) begin
                        div_cnt  <= '0;
                        cpu_ce_q <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                STEP: begin
                    if (bus.halt) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        cpu_ce_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    // HALTED is sticky until reset.
                    state_q <= HALTED;
                end
            endcase
        end
    end

    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.state     = state_q;
    assign bus.halted    = halted_q;
endmodule
